cond_unit: RTL and testbench

Condition-check and flags-register block in the execute stage of the RSA pipeline CPU. It latches the NZCV flags produced by the ALU and evaluates each instruction's 4-bit condition field against the stored flags. It then gates the instruction's write-back, memory-write and PC-source strobes, and optionally counts executed and annulled instructions. It is the consumer of the ALU flag interface: the ALU produces `ALUFlags`, this block stores and interprets them.

---
 rtl/cond_unit.sv | 92 +++++++++
 tb/tb_cond_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Condition-check and NZCV flags register for the EX stage.
// Optional saturating execute/squash counters are built when COND_PERF_CNT_EN is defined.
module cond_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ALUFlags_i,
  input  logic [3:0]       cond_i,
  input  logic [1:0]       flag_write_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             reg_write_i,
  input  logic             mem_write_i,
  input  logic             pcs_i,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             pcs_o,
  output logic             cond_ex_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
);

  logic [3:0] flags_q;
  logic       n, z, c, v;
  logic       go;

  assign flags_o      = flags_q;
  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      4'h0: cond_ex_o = z;
      4'h1: cond_ex_o = ~z;
      4'h2: cond_ex_o = c;
      4'h3: cond_ex_o = ~c;
      4'h4: cond_ex_o = n;
      4'h5: cond_ex_o = ~n;
      4'h6: cond_ex_o = v;
      4'h7: cond_ex_o = ~v;
      4'h8: cond_ex_o = c & ~z;
      4'h9: cond_ex_o = ~c | z;
      4'hA: cond_ex_o = (n == v);
      4'hB: cond_ex_o = (n != v);
      4'hC: cond_ex_o = ~z & (n == v);
      4'hD: cond_ex_o = z | (n != v);
      4'hE: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

  assign go          = valid_i & cond_ex_o & ~stall_i & ~flush_i & ~reset;
  assign reg_write_o = reg_write_i & go;
  assign mem_write_o = mem_write_i & go;
  assign pcs_o       = pcs_i & go;

  // N,Z and C,V halves are written independently; unwritten halves hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (go) begin
      if (flag_write_i[1]) flags_q[3:2] <= ALUFlags_i[3:2];
      if (flag_write_i[0]) flags_q[1:0] <= ALUFlags_i[1:0];
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q, squash_q;
  logic             squash;

  assign squash       = valid_i & ~cond_ex_o & ~stall_i & ~flush_i & ~reset;
  assign exec_cnt_o   = exec_q;
  assign squash_cnt_o = squash_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      if (go && (exec_q != '1))       exec_q   <= exec_q + CNT_W'(1);
      if (squash && (squash_q != '1)) squash_q <= squash_q + CNT_W'(1);
    end
  end
`else
  assign exec_cnt_o   = '0;
  assign squash_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit with a behavioural flags/condition/counter model.
module tb_cond_unit;
  localparam int unsigned CW = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          reset;
  logic [3:0]    alu, cond;
  logic [1:0]    fw;
  logic          valid, stall, flush, rw, mw, pcs;
  logic          rw_o, mw_o, pcs_o, ce_o;
  logic [3:0]    flags_o;
  logic [CW-1:0] exec_o, squash_o;

  int checks = 0;
  int errors = 0;

  // model state
  logic m_n, m_z, m_c, m_v;
  int   m_exec, m_squash;

  cond_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ALUFlags_i(alu), .cond_i(cond),
    .flag_write_i(fw), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .reg_write_i(rw), .mem_write_i(mw), .pcs_i(pcs),
    .reg_write_o(rw_o), .mem_write_o(mw_o), .pcs_o(pcs_o),
    .cond_ex_o(ce_o), .flags_o(flags_o),
    .exec_cnt_o(exec_o), .squash_cnt_o(squash_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ARM conditions come in pairs: odd code is the negation of the even one.
  function automatic logic ref_cond(input logic [3:0] cc);
    logic base;
    case (cc[3:1])
      3'd0: base = m_z;
      3'd1: base = m_c;
      3'd2: base = m_n;
      3'd3: base = m_v;
      3'd4: base = m_c && !m_z;
      3'd5: base = (m_n == m_v);
      3'd6: base = !m_z && (m_n == m_v);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  function automatic logic ref_go();
    return valid && ref_cond(cond) && !stall && !flush && !reset;
  endfunction

  function automatic logic [3:0] ref_flags();
    return {m_n, m_z, m_c, m_v};
  endfunction

  function automatic int exp_exec();
`ifdef COND_PERF_CNT_EN
    return m_exec;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_squash();
`ifdef COND_PERF_CNT_EN
    return m_squash;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] cc,
                       input logic [1:0] f, input logic vl, input logic st,
                       input logic fl, input logic [2:0] strobes);
    reset = r; alu = a; cond = cc; fw = f; valid = vl; stall = st; flush = fl;
    {rw, mw, pcs} = strobes;
    #1;
  endtask

  // Advance the model across the coming edge, then clock the DUT.
  task automatic edge_step();
    logic g, sq;
    g  = ref_go();
    sq = valid && !ref_cond(cond) && !stall && !flush && !reset;
    if (reset) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_exec = 0; m_squash = 0;
    end else begin
      if (g && fw[1]) {m_n, m_z} = alu[3:2];
      if (g && fw[0]) {m_c, m_v} = alu[1:0];
      if (g  && m_exec   < CMAX) m_exec++;
      if (sq && m_squash < CMAX) m_squash++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'hF, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 3'b111);
    checks++;
    if ({rw_o, mw_o, pcs_o} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got=%b exp=000", {rw_o, mw_o, pcs_o});
    end
    edge_step();
    checks++;
    if (flags_o !== 4'b0000 || exec_o !== '0 || squash_o !== '0) begin
      errors++; $display("FAIL reset_state flags=%b exec=%0d squash=%0d exp=0", flags_o, exec_o, squash_o);
    end
    drive(1'b0, 4'h0, 4'hE, 2'b00, 1'b1, 1'b0, 1'b0, 3'b100);
    checks++;
    if (rw_o !== 1'b1 || flags_o !== 4'b0000) begin
      errors++; $display("FAIL al_after_reset rw=%b flags=%b exp rw=1 flags=0000", rw_o, flags_o);
    end
    edge_step();
  endtask

  task automatic test_eq_ne();
    drive(1'b0, 4'b0100, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 3'b000);
    edge_step();
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b111);
    checks++;
    if (ce_o !== 1'b1 || flags_o !== 4'b0100) begin
      errors++; $display("FAIL eq_after_z ce=%b flags=%b exp ce=1 flags=0100", ce_o, flags_o);
    end
    drive(1'b0, 4'h0, 4'h1, 2'b00, 1'b1, 1'b0, 1'b0, 3'b111);
    checks++;
    if ({ce_o, rw_o, mw_o, pcs_o} !== 4'b0000) begin
      errors++; $display("FAIL ne_after_z got=%b exp=0000", {ce_o, rw_o, mw_o, pcs_o});
    end
    edge_step();
  endtask

  task automatic test_partial_write();
    drive(1'b0, 4'b1010, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 3'b000);
    edge_step();
    drive(1'b0, 4'b0101, 4'hE, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000);
    edge_step();
    checks++;
    if (flags_o !== 4'b0110) begin
      errors++; $display("FAIL partial_nz got=%b exp=0110", flags_o);
    end
    drive(1'b0, 4'b1001, 4'hE, 2'b01, 1'b1, 1'b0, 1'b0, 3'b000);
    edge_step();
    checks++;
    if (flags_o !== 4'b0101) begin
      errors++; $display("FAIL partial_cv got=%b exp=0101", flags_o);
    end
  endtask

  task automatic test_failed_cond();
    int e0, s0;
    logic [3:0] f0;
    f0 = flags_o; e0 = exp_exec(); s0 = exp_squash();
    drive(1'b0, ~f0, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 3'b111);
    checks++;
    if ({ce_o, rw_o, mw_o, pcs_o} !== 4'b0000) begin
      errors++; $display("FAIL failed_strobes got=%b exp=0000", {ce_o, rw_o, mw_o, pcs_o});
    end
    edge_step();
    checks++;
    if (flags_o !== f0) begin
      errors++; $display("FAIL failed_flags got=%b exp=%b", flags_o, f0);
    end
`ifdef COND_PERF_CNT_EN
    s0 = (s0 < CMAX) ? s0 + 1 : s0;
`endif
    checks++;
    if (int'(exec_o) !== e0 || int'(squash_o) !== s0) begin
      errors++; $display("FAIL failed_counters exec=%0d squash=%0d exp=%0d/%0d", exec_o, squash_o, e0, s0);
    end
  endtask

  task automatic test_stall();
    logic [3:0] f0, a;
    int e0, s0;
    f0 = flags_o; a = ~f0; e0 = int'(exec_o); s0 = int'(squash_o);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, a, 4'hE, 2'b11, 1'b1, 1'b1, 1'b0, 3'b111);
      checks++;
      if ({rw_o, mw_o, pcs_o} !== 3'b000) begin
        errors++; $display("FAIL stall_strobes cyc=%0d got=%b exp=000", i, {rw_o, mw_o, pcs_o});
      end
      edge_step();
      checks++;
      if (flags_o !== f0 || int'(exec_o) !== e0 || int'(squash_o) !== s0) begin
        errors++; $display("FAIL stall_hold cyc=%0d flags=%b exec=%0d squash=%0d exp=%b/%0d/%0d",
                           i, flags_o, exec_o, squash_o, f0, e0, s0);
      end
    end
    drive(1'b0, a, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 3'b111);
    checks++;
    if ({rw_o, mw_o, pcs_o} !== 3'b111) begin
      errors++; $display("FAIL stall_release_strobes got=%b exp=111", {rw_o, mw_o, pcs_o});
    end
    edge_step();
    checks++;
    if (flags_o !== a || int'(exec_o) !== exp_exec()) begin
      errors++; $display("FAIL stall_release_update flags=%b exec=%0d exp=%b/%0d", flags_o, exec_o, a, exp_exec());
    end
    f0 = flags_o; a = ~f0;
    drive(1'b0, a, 4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 3'b111);
    checks++;
    if ({rw_o, mw_o, pcs_o} !== 3'b000) begin
      errors++; $display("FAIL stall_flush_strobes got=%b exp=000", {rw_o, mw_o, pcs_o});
    end
    edge_step();
    checks++;
    if (flags_o !== f0) begin
      errors++; $display("FAIL stall_flush_flags got=%b exp=%b", flags_o, f0);
    end
  endtask

  task automatic test_saturate_and_reset();
    drive(1'b1, 4'h0, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000);
    edge_step();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 4'h0, 4'hE, 2'b00, 1'b1, 1'b0, 1'b0, 3'b100);
      edge_step();
    end
    checks++;
`ifdef COND_PERF_CNT_EN
    if (exec_o !== 4'd15 || m_exec != 15) begin
      errors++; $display("FAIL exec_saturate got=%0d exp=15", exec_o);
    end
`else
    if (exec_o !== '0) begin
      errors++; $display("FAIL exec_tied_zero got=%0d exp=0", exec_o);
    end
`endif
    drive(1'b0, 4'b1011, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 3'b000);
    edge_step();
    drive(1'b1, 4'hF, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 3'b111);
    checks++;
    if ({rw_o, mw_o, pcs_o} !== 3'b000) begin
      errors++; $display("FAIL midreset_strobes got=%b exp=000", {rw_o, mw_o, pcs_o});
    end
    edge_step();
    checks++;
    if (flags_o !== 4'b0000 || exec_o !== '0 || squash_o !== '0) begin
      errors++; $display("FAIL midreset_state flags=%b exec=%0d squash=%0d exp=0", flags_o, exec_o, squash_o);
    end
  endtask

  task automatic test_random();
    logic eg;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 24) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), 3'($urandom));
      eg = ref_go();
      checks++;
      if (ce_o !== ref_cond(cond) || {rw_o, mw_o, pcs_o} !== ({rw, mw, pcs} & {3{eg}})) begin
        errors++; $display("FAIL rand_comb i=%0d ce=%b strobes=%b exp ce=%b strobes=%b",
                           i, ce_o, {rw_o, mw_o, pcs_o}, ref_cond(cond), {rw, mw, pcs} & {3{eg}});
      end
      edge_step();
      checks++;
      if (flags_o !== ref_flags() || int'(exec_o) !== exp_exec() || int'(squash_o) !== exp_squash()) begin
        errors++; $display("FAIL rand_state i=%0d flags=%b exec=%0d squash=%0d exp=%b/%0d/%0d",
                           i, flags_o, exec_o, squash_o, ref_flags(), exp_exec(), exp_squash());
      end
    end
  endtask

  initial begin
    {m_n, m_z, m_c, m_v} = 4'b0000;
    m_exec = 0; m_squash = 0;
    test_reset();
    test_eq_ne();
    test_partial_write();
    test_failed_cond();
    test_stall();
    test_saturate_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
